// File: rtl/node_port_arbiter.sv
// Round-robin input scheduler: three per-port instruction FIFOs feeding one held output register.
// Optional macro ARB_DROP_COUNT_EN adds saturating per-port drop counters and a drop_clr input.
module node_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] self_data,
  input  logic              self_valid,
  input  logic [DATA_W-1:0] left_data,
  input  logic              left_valid,
  input  logic [DATA_W-1:0] right_data,
  input  logic              right_valid,
  output logic              self_full,
  output logic              left_full,
  output logic              right_full,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef ARB_DROP_COUNT_EN
  input  logic              drop_clr,
  output logic [7:0]        self_drops,
  output logic [7:0]        left_drops,
  output logic [7:0]        right_drops,
`endif
  output logic              busy
);

  localparam int NP = 3;
  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] in_dat [NP];
  logic [NP-1:0]     in_vld;
  logic [DATA_W-1:0] mem_q [NP][DEPTH];
  logic [PTR_W-1:0]  wptr_q [NP];
  logic [PTR_W-1:0]  wptr_d [NP];
  logic [PTR_W-1:0]  rptr_q [NP];
  logic [PTR_W-1:0]  rptr_d [NP];
  logic [CW-1:0]     cnt_q [NP];
  logic [CW-1:0]     cnt_d [NP];
  logic [NP-1:0]     full_q, full_d;
  logic [NP-1:0]     nonempty, push, pop;
  logic [1:0]        rr_q, rr_d, win;
  logic              found, load;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_src_q, out_src_d;

  // Port index reached k steps after base in the cyclic order self -> left -> right.
  function automatic logic [1:0] rot(input logic [1:0] base, input int k);
    logic [2:0] s;
    s = {1'b0, base} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign in_dat[0] = self_data;
  assign in_dat[1] = left_data;
  assign in_dat[2] = right_data;
  assign in_vld    = {right_valid, left_valid, self_valid};

  always_comb begin
    nonempty = '0;
    for (int p = 0; p < NP; p++) nonempty[p] = (cnt_q[p] != '0);
  end

  // First non-empty FIFO searching from the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < NP; k++) begin
      if (!found && nonempty[rot(rr_q, k)]) begin
        found = 1'b1;
        win   = rot(rr_q, k);
      end
    end
  end

  assign load = found && ((state_q == IDLE) || out_ready);

  // A full FIFO still accepts a push on the edge that pops it.
  always_comb begin
    pop  = '0;
    push = '0;
    for (int p = 0; p < NP; p++) begin
      pop[p]    = load && (win == 2'(p));
      push[p]   = in_vld[p] && ((cnt_q[p] != FULL_CNT) || pop[p]);
      wptr_d[p] = push[p] ? wptr_q[p] + PTR_W'(1) : wptr_q[p];
      rptr_d[p] = pop[p]  ? rptr_q[p] + PTR_W'(1) : rptr_q[p];
      cnt_d[p]  = cnt_q[p];
      if (push[p] && !pop[p])      cnt_d[p] = cnt_q[p] + CW'(1);
      else if (pop[p] && !push[p]) cnt_d[p] = cnt_q[p] - CW'(1);
      full_d[p] = (cnt_d[p] == FULL_CNT);
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    rr_d       = rr_q;
    if (load) begin
      out_data_d = mem_q[win][rptr_q[win]];
      out_src_d  = win;
      rr_d       = rot(win, 1);
    end
    case (state_q)
      IDLE:    if (found) state_d = HOLD;
      HOLD:    if (out_ready && !found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 2'd0;
      full_q     <= '0;
      out_data_q <= '0;
      out_src_q  <= 2'd0;
      for (int p = 0; p < NP; p++) begin
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      full_q     <= full_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      for (int p = 0; p < NP; p++) begin
        wptr_q[p] <= wptr_d[p];
        rptr_q[p] <= rptr_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
    end
  end

  // Storage needs no reset: the counts alone decide what is readable.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) mem_q[p][wptr_q[p]] <= in_dat[p];
    end
  end

`ifdef ARB_DROP_COUNT_EN
  logic [7:0] drops_q [NP];
  logic [7:0] drops_d [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      drops_d[p] = drops_q[p];
      if (drop_clr)
        drops_d[p] = 8'd0;
      else if (in_vld[p] && !push[p] && (drops_q[p] != 8'hFF))
        drops_d[p] = drops_q[p] + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) drops_q[p] <= 8'd0;
    end else begin
      for (int p = 0; p < NP; p++) drops_q[p] <= drops_d[p];
    end
  end

  assign self_drops  = drops_q[0];
  assign left_drops  = drops_q[1];
  assign right_drops = drops_q[2];
`endif

  assign self_full  = full_q[0];
  assign left_full  = full_q[1];
  assign right_full = full_q[2];
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign out_valid  = (state_q == HOLD);
  assign busy       = (|nonempty) || out_valid;

endmodule

// File: tb/tb_node_port_arbiter.sv
// Bench for node_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_node_port_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] self_data = '0, left_data = '0, right_data = '0;
  logic          self_valid = 1'b0, left_valid = 1'b0, right_valid = 1'b0;
  logic          self_full, left_full, right_full;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
`ifdef ARB_DROP_COUNT_EN
  logic          drop_clr = 1'b0;
  logic [7:0]    self_drops, left_drops, right_drops;
`endif

  int checks = 0;
  int errors = 0;

  node_port_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .self_data(self_data), .self_valid(self_valid),
    .left_data(left_data), .left_valid(left_valid),
    .right_data(right_data), .right_valid(right_valid),
    .self_full(self_full), .left_full(left_full), .right_full(right_full),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef ARB_DROP_COUNT_EN
    .drop_clr(drop_clr), .self_drops(self_drops),
    .left_drops(left_drops), .right_drops(right_drops),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per port, a held output word and a rotating start port.
  logic [DW-1:0] q0[$], q1[$], q2[$];
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_src, m_ptr;
  int            m_drops[3];

  always @(posedge clk or negedge rst_n) begin
    int sz[3];
    bit vin[3];
    logic [DW-1:0] din[3];
    int win, p;
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete();
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
      for (int i = 0; i < 3; i++) m_drops[i] = 0;
    end else begin
      sz[0] = q0.size(); sz[1] = q1.size(); sz[2] = q2.size();
      vin[0] = self_valid; vin[1] = left_valid; vin[2] = right_valid;
      din[0] = self_data;  din[1] = left_data;  din[2] = right_data;
      win = -1;
      if (!m_valid || out_ready) begin
        for (int k = 0; k < 3; k++) begin
          p = (m_ptr + k) % 3;
          if (win < 0 && sz[p] > 0) win = p;
        end
      end
      if (win >= 0) begin
        case (win)
          0: m_data = q0.pop_front();
          1: m_data = q1.pop_front();
          default: m_data = q2.pop_front();
        endcase
        m_src = win; m_ptr = (win + 1) % 3; m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (vin[i]) begin
          if (sz[i] < DEPTH || win == i) begin
            case (i)
              0: q0.push_back(din[i]);
              1: q1.push_back(din[i]);
              default: q2.push_back(din[i]);
            endcase
          end else if (m_drops[i] < 255) begin
            m_drops[i]++;
          end
        end
      end
`ifdef ARB_DROP_COUNT_EN
      if (drop_clr) for (int i = 0; i < 3; i++) m_drops[i] = 0;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    self_valid = 0; left_valid = 0; right_valid = 0; out_ready = 0;
`ifdef ARB_DROP_COUNT_EN
    drop_clr = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    self_valid = 1; left_valid = 1; right_valid = 1; out_ready = 1;
    self_data = 32'h1; left_data = 32'h2; right_data = 32'h3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, busy, self_full, left_full, right_full} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got vld/busy/full=%b required 00000", i,
                 {out_valid, busy, self_full, left_full, right_full});
      end
      checks++;
      if (out_data !== 32'h0 || out_src !== 2'b00) begin
        errors++;
        $display("FAIL reset_out got data=%h src=%b required 0/00", out_data, out_src);
      end
    end
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc%0d got valid=%b busy=%b required 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    self_valid = 1; self_data = 32'hDEADBEEF; out_ready = 1;
    tick();
    self_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got valid=%b busy=%b required 0 1", out_valid, busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 2'b00) begin
      errors++;
      $display("FAIL single_grant got valid=%b data=%h src=%b required 1 deadbeef 00",
               out_valid, out_data, out_src);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] ed[4];
    logic [1:0]    es[4];
    ed[0] = 32'h1; ed[1] = 32'hA; ed[2] = 32'hB; ed[3] = 32'h2;
    es[0] = 2'b00; es[1] = 2'b01; es[2] = 2'b10; es[3] = 2'b00;
    do_reset();
    self_valid = 1; self_data = 32'h1; left_valid = 1; left_data = 32'hA;
    right_valid = 1; right_data = 32'hB;
    tick();
    left_valid = 0; right_valid = 0; self_data = 32'h2;
    tick();
    self_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ed[i] || out_src !== es[i]) begin
        errors++;
        $display("FAIL rr_grant%0d got valid=%b data=%h src=%b required 1 %h %b",
                 i, out_valid, out_data, out_src, ed[i], es[i]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain got valid=%b required 0", out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure_full();
    logic [DW-1:0] ed[5];
    logic [1:0]    es[5];
    logic          ef[5];
    ed[0] = 32'h22; ed[1] = 32'hC1; ed[2] = 32'hC2; ed[3] = 32'hC3; ed[4] = 32'hC5;
    es[0] = 2'b10;  es[1] = 2'b01;  es[2] = 2'b01;  es[3] = 2'b01;  es[4] = 2'b01;
    ef[0] = 1'b1;   ef[1] = 1'b0;   ef[2] = 1'b0;   ef[3] = 1'b0;   ef[4] = 1'b0;
    do_reset();
    self_valid = 1; self_data = 32'h11; right_valid = 1; right_data = 32'h22;
    tick();
    self_valid = 0; right_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h11 || out_src !== 2'b00) begin
        errors++;
        $display("FAIL bp_stable%0d got valid=%b data=%h src=%b required 1 11 00",
                 i, out_valid, out_data, out_src);
      end
    end
    for (int i = 0; i < 5; i++) begin
      left_valid = 1; left_data = 32'hC0 + DW'(i);
      tick();
      checks++;
      if (left_full !== (i >= 3)) begin
        errors++;
        $display("FAIL left_full_push%0d got %b required %b", i, left_full, (i >= 3));
      end
    end
    left_valid = 0;
`ifdef ARB_DROP_COUNT_EN
    checks++;
    if (left_drops !== 8'd1 || self_drops !== 8'd0 || right_drops !== 8'd0) begin
      errors++;
      $display("FAIL drop_count got s/l/r=%0d/%0d/%0d required 0/1/0",
               self_drops, left_drops, right_drops);
    end
`endif
    out_ready = 1; left_valid = 1; left_data = 32'hC5;
    tick();
    left_valid = 0;
    checks++;
    if (out_data !== 32'hC0 || out_src !== 2'b01 || left_full !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_push got data=%h src=%b full=%b required c0 01 1",
               out_data, out_src, left_full);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ed[i] || out_src !== es[i] || left_full !== ef[i]) begin
        errors++;
        $display("FAIL order%0d got valid=%b data=%h src=%b full=%b required 1 %h %b %b",
                 i, out_valid, out_data, out_src, left_full, ed[i], es[i], ef[i]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got valid=%b busy=%b required 0 0", out_valid, busy);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    self_valid = 1; self_data = 32'h51; left_valid = 1; left_data = 32'h52;
    right_valid = 1; right_data = 32'h53;
    tick();
    left_valid = 0; right_valid = 0; self_data = 32'h54;
    tick();
    self_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h51) begin
      errors++;
      $display("FAIL mid_setup got valid=%b data=%h required 1 51", out_valid, out_data);
    end
    rst_n = 0;
    #2;
    checks++;
    if ({out_valid, busy, self_full, left_full, right_full} !== 5'b0 ||
        out_data !== 32'h0 || out_src !== 2'b00) begin
      errors++;
      $display("FAIL mid_async got vld/busy/full=%b data=%h src=%b required 00000 0 00",
               {out_valid, busy, self_full, left_full, right_full}, out_data, out_src);
    end
    tick();
    rst_n = 1; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale%0d got valid=%b data=%h busy=%b required 0 0", i,
                 out_valid, out_data, busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int lim;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      lim = (i < 300) ? 3 : 7;
      self_valid  = ($urandom_range(0, 1) == 1);
      left_valid  = ($urandom_range(0, 2) != 0);
      right_valid = ($urandom_range(0, 1) == 1);
      self_data = $urandom(); left_data = $urandom(); right_data = $urandom();
      out_ready = ($urandom_range(0, 9) < lim);
`ifdef ARB_DROP_COUNT_EN
      drop_clr = ($urandom_range(0, 31) == 0);
`endif
      tick();
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL rnd_valid cyc%0d got %b required %b", i, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (out_data !== m_data || out_src !== 2'(m_src)) begin
          errors++;
          $display("FAIL rnd_data cyc%0d got %h/%b required %h/%0d", i, out_data, out_src,
                   m_data, m_src);
        end
      end
      checks++;
      if ({right_full, left_full, self_full} !==
          {q2.size() == DEPTH, q1.size() == DEPTH, q0.size() == DEPTH}) begin
        errors++;
        $display("FAIL rnd_full cyc%0d got %b required sizes %0d/%0d/%0d", i,
                 {right_full, left_full, self_full}, q0.size(), q1.size(), q2.size());
      end
      checks++;
      if (busy !== (m_valid || q0.size() > 0 || q1.size() > 0 || q2.size() > 0)) begin
        errors++;
        $display("FAIL rnd_busy cyc%0d got %b", i, busy);
      end
`ifdef ARB_DROP_COUNT_EN
      checks++;
      if (self_drops !== 8'(m_drops[0]) || left_drops !== 8'(m_drops[1]) ||
          right_drops !== 8'(m_drops[2])) begin
        errors++;
        $display("FAIL rnd_drops cyc%0d got %0d/%0d/%0d required %0d/%0d/%0d", i,
                 self_drops, left_drops, right_drops, m_drops[0], m_drops[1], m_drops[2]);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
